// File: rtl/uart_frame_if.sv
// uart_frame_if: byte input, frame output and error signals of uart_frame_ctrl.
// master is the frame controller side, slave is the receiver/consumer side.
interface uart_frame_if;
    logic        rx_done;
    logic [7:0]  rx_data;
    logic        frame_ack;
    logic        frame_valid;
    logic [7:0]  frame_cmd;
    logic [2:0]  frame_len;
    logic [31:0] frame_payload;
    logic        frame_err;
    logic [1:0]  err_code;
    logic        busy;

    modport master (
        input  rx_done,
        input  rx_data,
        input  frame_ack,
        output frame_valid,
        output frame_cmd,
        output frame_len,
        output frame_payload,
        output frame_err,
        output err_code,
        output busy
    );

    modport slave (
        output rx_done,
        output rx_data,
        output frame_ack,
        input  frame_valid,
        input  frame_cmd,
        input  frame_len,
        input  frame_payload,
        input  frame_err,
        input  err_code,
        input  busy
    );
endinterface

// File: rtl/uart_frame_ctrl.sv
// uart_frame_ctrl: assembles HEADER/CMD/LEN/payload/CHK frames from UART bytes.
// Define UART_FRAME_TIMEOUT_EN to abort partial frames after an inter-byte timeout.
module uart_frame_ctrl #(
    parameter int unsigned CLK_FREQ      = 24000000,
    parameter int unsigned UART_BPS      = 9600,
    parameter logic [7:0]  HEADER        = 8'hAA,
    parameter int unsigned TIMEOUT_BYTES = 4
) (
    input logic          clock,
    input logic          reset,
    uart_frame_if.master bus
);
    localparam logic [23:0] TIMEOUT_CYC =
        24'(TIMEOUT_BYTES * 10 * CLK_FREQ / UART_BPS);

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        LEN,
        DATA,
        CHK
    } state_t;

    state_t      state_q, state_d;
    logic        done_q;
    logic [2:0]  cnt_q, cnt_d;
    logic [7:0]  acc_q, acc_d;
    logic [7:0]  cmd_q, cmd_d;
    logic [2:0]  len_q, len_d;
    logic [31:0] pay_q, pay_d;

    logic        valid_q;
    logic [7:0]  fcmd_q;
    logic [2:0]  flen_q;
    logic [31:0] fpay_q;
    logic        err_q, err_d;
    logic [1:0]  code_q, code_d;
    logic        load;
    logic        byte_stb;
    logic        tmo_hit;

    // rx_done is level-held for a whole byte time; act only on its rise
    assign byte_stb = bus.rx_done & ~done_q;

`ifdef UART_FRAME_TIMEOUT_EN
    logic [23:0] tmo_q;

    assign tmo_hit = (state_q != IDLE) && !byte_stb &&
                     (tmo_q == TIMEOUT_CYC - 24'd1);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tmo_q <= '0;
        end else if (byte_stb || state_q == IDLE || tmo_hit) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_q + 24'd1;
        end
    end
`else
    logic unused_tmo;

    assign tmo_hit    = 1'b0;
    assign unused_tmo = ^TIMEOUT_CYC;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        cmd_d   = cmd_q;
        len_d   = len_q;
        pay_d   = pay_q;
        load    = 1'b0;
        err_d   = 1'b0;
        code_d  = code_q;
        if (byte_stb) begin
            unique case (state_q)
                IDLE: begin
                    if (bus.rx_data == HEADER) begin
                        state_d = CMD;
                        cnt_d   = '0;
                        pay_d   = '0;
                    end
                end
                CMD: begin
                    cmd_d   = bus.rx_data;
                    acc_d   = bus.rx_data;
                    state_d = LEN;
                end
                LEN: begin
                    if (bus.rx_data > 8'd4) begin
                        err_d   = 1'b1;
                        code_d  = 2'd1;
                        state_d = IDLE;
                    end else begin
                        len_d   = bus.rx_data[2:0];
                        acc_d   = acc_q ^ bus.rx_data;
                        state_d = (bus.rx_data == 8'd0) ? CHK : DATA;
                    end
                end
                DATA: begin
                    pay_d[{cnt_q[1:0], 3'b000} +: 8] = bus.rx_data;
                    acc_d = acc_q ^ bus.rx_data;
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == len_q - 3'd1) begin
                        state_d = CHK;
                    end
                end
                CHK: begin
                    state_d = IDLE;
                    if (bus.rx_data != acc_q) begin
                        err_d  = 1'b1;
                        code_d = 2'd2;
                    end else if (valid_q && !bus.frame_ack) begin
                        // held frame not consumed yet: drop the new one
                        err_d  = 1'b1;
                        code_d = 2'd0;
                    end else begin
                        load = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if (tmo_hit) begin
            state_d = IDLE;
            err_d   = 1'b1;
            code_d  = 2'd3;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            acc_q   <= '0;
            cmd_q   <= '0;
            len_q   <= '0;
            pay_q   <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= bus.rx_done;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            cmd_q   <= cmd_d;
            len_q   <= len_d;
            pay_q   <= pay_d;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            fcmd_q  <= '0;
            flen_q  <= '0;
            fpay_q  <= '0;
            err_q   <= 1'b0;
            code_q  <= '0;
        end else begin
            err_q  <= err_d;
            code_q <= code_d;
            if (load) begin
                valid_q <= 1'b1;
                fcmd_q  <= cmd_q;
                flen_q  <= len_q;
                fpay_q  <= pay_q;
            end else if (bus.frame_ack && valid_q) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign bus.frame_valid   = valid_q;
    assign bus.frame_cmd     = fcmd_q;
    assign bus.frame_len     = flen_q;
    assign bus.frame_payload = fpay_q;
    assign bus.frame_err     = err_q;
    assign bus.err_code      = code_q;
    assign bus.busy          = (state_q != IDLE);

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// tb_uart_frame_ctrl: vector table, hand sequences and randomized frames
// checked against a frame-level reference model of uart_frame_ctrl.
module tb_uart_frame_ctrl;
    logic clock = 1'b0;
    logic reset = 1'b0;

    always #5 clock = ~clock;

    uart_frame_if bus();

    uart_frame_ctrl dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.master)
    );

    int tests = 0;
    int fails = 0;
    int unsigned cyc = 0;
    int unsigned err_seen = 0;

    always @(posedge clock) cyc <= cyc + 1;
    always @(negedge clock) if (bus.frame_err === 1'b1) err_seen++;

    typedef struct {
        logic [63:0] bytes;
        int          n;
        int          hold;
        logic        exp_v;
        logic [7:0]  cmd;
        logic [2:0]  len;
        logic [31:0] pay;
        logic        exp_e;
        logic [1:0]  code;
    } vec_t;

    vec_t vt[7];

    logic        s_pre, s_valid, s_err, s_err2;
    logic [1:0]  s_code;
    logic [7:0]  s_cmd;
    logic [2:0]  s_len;
    logic [31:0] s_pay;
    int unsigned s_cyc;

    logic        rv;
    logic [7:0]  rcmd;
    logic [2:0]  rlen;
    logic [31:0] rpay;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int hold,
                             input int gap, input logic ack);
        @(posedge clock);
        #1;
        bus.rx_data   = b;
        bus.rx_done   = 1'b1;
        bus.frame_ack = ack;
        s_pre = bus.frame_valid;
        @(posedge clock);
        #1;
        bus.frame_ack = 1'b0;
        @(negedge clock);
        s_valid = bus.frame_valid;
        s_err   = bus.frame_err;
        s_code  = bus.err_code;
        s_cmd   = bus.frame_cmd;
        s_len   = bus.frame_len;
        s_pay   = bus.frame_payload;
        s_cyc   = cyc;
        @(negedge clock);
        s_err2 = bus.frame_err;
        repeat (hold) @(posedge clock);
        #1;
        bus.rx_done = 1'b0;
        repeat (gap) @(posedge clock);
    endtask

    task automatic do_ack();
        @(posedge clock);
        #1 bus.frame_ack = 1'b1;
        @(posedge clock);
        #1 bus.frame_ack = 1'b0;
        @(negedge clock);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  x, b, cmdb, lb;
        logic [31:0] pay;
        int          kind, n, l, h, g;
        int unsigned e0, stb;

        bus.rx_done   = 1'b0;
        bus.rx_data   = 8'h00;
        bus.frame_ack = 1'b0;

        vt[0] = '{bytes: 64'h0000_2534_1202_01AA, n: 6, hold: 1250,
                  exp_v: 1'b1, cmd: 8'h01, len: 3'd2, pay: 32'h0000_3412,
                  exp_e: 1'b0, code: 2'd0};
        vt[1] = '{bytes: 64'h0000_0700_07AA_0055, n: 6, hold: 3,
                  exp_v: 1'b1, cmd: 8'h07, len: 3'd0, pay: 32'h0,
                  exp_e: 1'b0, code: 2'd0};
        vt[2] = '{bytes: 64'h0000_0000_0600_05AA, n: 4, hold: 2,
                  exp_v: 1'b0, cmd: 8'h00, len: 3'd0, pay: 32'h0,
                  exp_e: 1'b1, code: 2'd2};
        vt[3] = '{bytes: 64'h0000_0000_0005_01AA, n: 3, hold: 4,
                  exp_v: 1'b0, cmd: 8'h00, len: 3'd0, pay: 32'h0,
                  exp_e: 1'b1, code: 2'd1};
        vt[4] = '{bytes: 64'h4344_3322_1104_03AA, n: 8, hold: 2,
                  exp_v: 1'b1, cmd: 8'h03, len: 3'd4, pay: 32'h4433_2211,
                  exp_e: 1'b0, code: 2'd0};
        vt[5] = '{bytes: 64'h0000_00F1_5A01_AAAA, n: 5, hold: 5,
                  exp_v: 1'b1, cmd: 8'hAA, len: 3'd1, pay: 32'h0000_005A,
                  exp_e: 1'b0, code: 2'd0};
        vt[6] = '{bytes: 64'h0013_0302_0103_10AA, n: 7, hold: 2,
                  exp_v: 1'b1, cmd: 8'h10, len: 3'd3, pay: 32'h0003_0201,
                  exp_e: 1'b0, code: 2'd0};

        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_valid", bus.frame_valid, 0);
        chk("rst_outs", {bus.frame_cmd, bus.frame_len, bus.err_code,
                         bus.frame_err, bus.busy}, 0);
        chk("rst_pay", bus.frame_payload, 0);
        reset = 1'b1;

        for (int i = 0; i < 7; i++) begin
            for (int j = 0; j < vt[i].n; j++) begin
                send_byte(vt[i].bytes[8*j +: 8], vt[i].hold, 1, 1'b0);
            end
            chk($sformatf("vec%0d_pre_valid", i), s_pre, 0);
            chk($sformatf("vec%0d_valid", i), s_valid, vt[i].exp_v);
            chk($sformatf("vec%0d_err", i), s_err, vt[i].exp_e);
            chk($sformatf("vec%0d_err_one_cycle", i), s_err2, 0);
            chk($sformatf("vec%0d_idle", i), bus.busy, 0);
            if (vt[i].exp_e) begin
                chk($sformatf("vec%0d_code", i), s_code, vt[i].code);
            end
            if (vt[i].exp_v) begin
                chk($sformatf("vec%0d_cmd", i), s_cmd, vt[i].cmd);
                chk($sformatf("vec%0d_len", i), s_len, vt[i].len);
                chk($sformatf("vec%0d_pay", i), s_pay, vt[i].pay);
                do_ack();
                chk($sformatf("vec%0d_ack_valid", i), bus.frame_valid, 0);
                chk($sformatf("vec%0d_ack_cmd", i), bus.frame_cmd, vt[i].cmd);
            end
        end

        // randomized frames against a frame-level model
        rv = 1'b0;
        rcmd = '0;
        rlen = '0;
        rpay = '0;
        for (int t = 0; t < 40; t++) begin
            kind = $urandom_range(0, 3);
            h = $urandom_range(1, 5);
            g = $urandom_range(0, 3);
            if (rv && ($urandom_range(0, 1) == 1)) begin
                do_ack();
                chk("rnd_ack", bus.frame_valid, 0);
                rv = 1'b0;
            end
            if (kind == 3) begin
                n = $urandom_range(1, 3);
                for (int k = 0; k < n; k++) begin
                    b = 8'($urandom);
                    if (b == 8'hAA) b = 8'h55;
                    send_byte(b, h, g, 1'b0);
                end
            end
            send_byte(8'hAA, h, g, 1'b0);
            cmdb = 8'($urandom);
            send_byte(cmdb, h, g, 1'b0);
            if (kind == 2) begin
                lb = 8'($urandom_range(5, 255));
                send_byte(lb, h, g, 1'b0);
                chk("rnd_badlen_err", {s_err, s_code}, {1'b1, 2'd1});
                chk("rnd_badlen_valid", s_valid, rv);
            end else begin
                l = $urandom_range(0, 4);
                lb = 8'(l);
                send_byte(lb, h, g, 1'b0);
                x = cmdb ^ lb;
                pay = '0;
                for (int k = 0; k < l; k++) begin
                    b = 8'($urandom);
                    pay = pay | (32'(b) << (8 * k));
                    x = x ^ b;
                    send_byte(b, h, g, 1'b0);
                end
                if (kind == 1) x = x ^ 8'($urandom_range(1, 255));
                send_byte(x, h, g, 1'b0);
                if (kind == 1) begin
                    chk("rnd_badchk_err", {s_err, s_code}, {1'b1, 2'd2});
                    chk("rnd_badchk_valid", s_valid, rv);
                end else if (rv) begin
                    chk("rnd_ovr_err", {s_err, s_code}, {1'b1, 2'd0});
                    chk("rnd_ovr_hold", {s_valid, s_cmd, s_len},
                        {1'b1, rcmd, rlen});
                    chk("rnd_ovr_pay", s_pay, rpay);
                end else begin
                    chk("rnd_good_err", s_err, 0);
                    chk("rnd_good_frame", {s_valid, s_cmd, s_len},
                        {1'b1, cmdb, 3'(l)});
                    chk("rnd_good_pay", s_pay, pay);
                    rv = 1'b1;
                    rcmd = cmdb;
                    rlen = 3'(l);
                    rpay = pay;
                end
            end
            chk("rnd_idle", bus.busy, 0);
        end
        if (rv) begin
            do_ack();
            chk("rnd_final_ack", bus.frame_valid, 0);
        end

        // overrun: frame A held, frame B dropped
        send_byte(8'hAA, 2, 0, 1'b0);
        send_byte(8'h01, 2, 0, 1'b0);
        send_byte(8'h00, 2, 0, 1'b0);
        send_byte(8'h01, 2, 0, 1'b0);
        chk("ovr_a_frame", {s_valid, s_cmd, s_err}, {1'b1, 8'h01, 1'b0});
        send_byte(8'hAA, 2, 0, 1'b0);
        send_byte(8'h02, 2, 0, 1'b0);
        send_byte(8'h00, 2, 0, 1'b0);
        send_byte(8'h02, 2, 0, 1'b0);
        chk("ovr_b_err", {s_err, s_code}, {1'b1, 2'd0});
        chk("ovr_b_hold", {s_valid, s_cmd}, {1'b1, 8'h01});
        // ack coincident with the CHK strobe: new frame replaces held one
        send_byte(8'hAA, 2, 0, 1'b0);
        send_byte(8'h02, 2, 0, 1'b0);
        send_byte(8'h00, 2, 0, 1'b0);
        send_byte(8'h02, 2, 0, 1'b1);
        chk("ack_same_err", s_err, 0);
        chk("ack_same_frame", {s_valid, s_cmd}, {1'b1, 8'h02});
        chk("ack_same_stays", bus.frame_valid, 1);
        do_ack();
        chk("ack_clear", bus.frame_valid, 0);
        e0 = err_seen;
        do_ack();
        chk("ack_idle_ignored", {bus.frame_valid, bus.frame_cmd},
            {1'b0, 8'h02});
        chk("ack_idle_no_err", err_seen - e0, 0);

        // reset in DATA with a frame held and err_code nonzero
        send_byte(8'hAA, 2, 0, 1'b0);
        send_byte(8'h07, 2, 0, 1'b0);
        send_byte(8'h00, 2, 0, 1'b0);
        send_byte(8'h07, 2, 0, 1'b0);
        chk("prerst_frame", {s_valid, s_cmd}, {1'b1, 8'h07});
        send_byte(8'hAA, 2, 0, 1'b0);
        send_byte(8'h01, 2, 0, 1'b0);
        send_byte(8'h05, 2, 0, 1'b0);
        chk("prerst_code", {s_err, s_code}, {1'b1, 2'd1});
        send_byte(8'hAA, 2, 0, 1'b0);
        send_byte(8'h03, 2, 0, 1'b0);
        send_byte(8'h04, 2, 0, 1'b0);
        send_byte(8'h11, 2, 0, 1'b0);
        chk("prerst_busy", bus.busy, 1);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("midrst_outs", {bus.frame_valid, bus.frame_cmd, bus.frame_len,
                            bus.err_code, bus.frame_err, bus.busy}, 0);
        chk("midrst_pay", bus.frame_payload, 0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        for (int j = 0; j < 6; j++) begin
            send_byte(vt[0].bytes[8*j +: 8], 3, 1, 1'b0);
        end
        chk("postrst_frame", {s_valid, s_cmd, s_len, s_err},
            {1'b1, 8'h01, 3'd2, 1'b0});
        chk("postrst_pay", s_pay, 32'h0000_3412);
        do_ack();

        // partial frame: AA 01 then silence
        e0 = err_seen;
        send_byte(8'hAA, 2, 0, 1'b0);
        send_byte(8'h01, 2, 0, 1'b0);
        stb = s_cyc;
`ifdef UART_FRAME_TIMEOUT_EN
        while (bus.frame_err !== 1'b1 && (cyc - stb) < 200000) begin
            @(negedge clock);
        end
        chk("tmo_delay", cyc - stb, 100000);
        chk("tmo_code", {bus.frame_err, bus.err_code}, {1'b1, 2'd3});
        chk("tmo_busy", bus.busy, 0);
`else
        repeat (300) @(posedge clock);
        @(negedge clock);
        chk("notmo_busy", bus.busy, 1);
        chk("notmo_no_err", err_seen - e0, 0);
        chk("notmo_wait", cyc - stb >= 300, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_frame_ctrl.md
Name: uart_frame_ctrl

Overview:
- Frame controller behind the UART receiver. It consumes the receiver's byte-done / byte-data outputs and assembles command frames for the parking-control logic.
- Frame format: HEADER, CMD, LEN (0..4), LEN payload bytes, CHK, where CHK = XOR of CMD, LEN and all payload bytes.
- Good frames are presented on a valid/ack interface. Malformed, late or overrun frames are reported as a one-cycle error pulse with a code.

Parameters:
- CLK_FREQ, 24000000, system clock frequency in Hz.
- UART_BPS, 9600, line baud rate.
- HEADER, 8'hAA, start-of-frame byte.
- TIMEOUT_BYTES, 4, inter-byte timeout expressed in byte times. TIMEOUT_CYC = TIMEOUT_BYTES*10*CLK_FREQ/UART_BPS (100000 at defaults); counter is 24 bits.

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- rx_done  in  1  receiver byte-done; stays high for many cycles per byte.
- rx_data  in  8  receiver byte; valid while rx_done is high.
- frame_ack  in  1  consumer accepts the held frame.
- frame_valid  out  1  frame held on the outputs; stays high until acked.
- frame_cmd  out  8  CMD byte.
- frame_len  out  3  payload length, 0..4.
- frame_payload  out  32  payload; first byte in [7:0]; unused bytes are 0.
- frame_err  out  1  one-cycle error pulse.
- err_code  out  2  0=overrun, 1=bad length, 2=checksum, 3=timeout; valid with frame_err, holds last value otherwise.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset (async, active-low): state IDLE; all outputs 0; done_d, byte counter, XOR accumulator, payload shift register and timeout counter all 0.
- Byte strobe: byte_stb = rx_done & ~done_d, where done_d is rx_done registered. Exactly one strobe per rising edge of rx_done, however long rx_done stays high. rx_data is sampled on the strobe cycle.
- States and transitions, evaluated only when byte_stb is high:
  - IDLE: byte == HEADER -> CMD. Any other byte is ignored, with no error.
  - CMD: store cmd; acc = byte -> LEN. A byte equal to HEADER here is treated as data.
  - LEN: if byte > 4, pulse err code 1 and go IDLE. Otherwise store len and set acc ^= byte; go to DATA if len != 0, else CHK.
  - DATA: load payload byte at index cnt; acc ^= byte; cnt++. Go to CHK when cnt reaches len-1.
  - CHK: if byte == acc, complete the frame; otherwise pulse err code 2. Go IDLE in both cases.
- Completion:
  - frame_valid, frame_cmd, frame_len and frame_payload load on the same clock edge that samples the CHK strobe. Latency is 1 cycle from rx_done rising.
  - If frame_valid = 1 and frame_ack = 0 at completion, the new frame is dropped, the held frame is unchanged, and err code 0 is pulsed.
  - Completion and frame_ack in the same cycle: the new frame is loaded and frame_valid stays high.
- Ack: frame_ack while frame_valid is high clears frame_valid on the next edge. Data outputs keep their values. frame_ack while frame_valid is low is ignored.
- Internal payload register is cleared on HEADER acceptance, so short frames present zeros in unused bytes.
- Reset mid-frame: abort immediately and discard the held frame; no error pulse.

Optional Feature:
- Macro: UART_FRAME_TIMEOUT_EN.
- Defined:
  - The timeout counter clears on every byte_stb and in IDLE, and increments each cycle in any other state.
  - When it reaches TIMEOUT_CYC-1: go IDLE, pulse err code 3, clear the counter.
  - If a byte_stb lands in the same cycle as expiry, the byte wins and no timeout occurs.
- Undefined: no counter logic; a partial frame waits indefinitely for its remaining bytes. Err code 3 is never produced.

Test Plan:
1. Send AA 01 02 12 34 25, each with rx_done held 1250 cycles. Required: frame_valid rises 1 cycle after the last rx_done rise; cmd=0x01, len=2, payload=0x00003412; no frame_err.
2. Send noise 55 00 then AA 07 00 07. Required: noise ignored; frame cmd=0x07, len=0, payload=0; then frame_ack -> frame_valid low on the next edge.
3. Send AA 05 00 06. Required: frame_err pulse with err_code=2, frame_valid stays 0. Send AA 01 05. Required: err_code=1 at the LEN byte, return to IDLE.
4. Complete frame A (AA 01 00 01), do not ack, then complete frame B (AA 02 00 02). Required: err_code=0, outputs still show cmd=0x01. Repeat with frame_ack asserted in the same cycle as B's CHK strobe. Required: cmd=0x02, frame_valid stays 1.
5. With UART_FRAME_TIMEOUT_EN defined, send AA 01 and stop. Required: err_code=3 exactly 100000 cycles after the 0x01 strobe, busy drops. Without the macro: busy stays high.
6. Assert reset in the DATA state. Required: all outputs 0 immediately. After release, send AA 01 02 12 34 25 again. Required: it decodes correctly.
